// File: rtl/stock_pile_reader.sv
// stock_pile_reader: LIFO waste pile with a pop handshake and a bottom-first recycle stream.
// Define STOCK_READER_ERR_EN to enable the err_underflow / err_overflow pulses.
module stock_pile_reader #(
  parameter int CARD_SIZE  = 6,
  parameter int PILE_DEPTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  input  logic [CARD_SIZE-1:0] push_card,
  output logic                 push_ready,
  input  logic                 pop_req,
  output logic                 pop_valid,
  output logic [CARD_SIZE-1:0] pop_card,
  input  logic                 pop_ack,
  input  logic                 recycle_start,
  output logic                 recycle_valid,
  output logic [CARD_SIZE-1:0] recycle_card,
  output logic                 recycle_last,
  output logic                 recycle_done,
  output logic [4:0]           pile_size,
  output logic                 empty,
  output logic                 full,
  output logic                 err_underflow,
  output logic                 err_overflow
);
  typedef enum logic [1:0] {IDLE, POP, RECYCLE, DONE} state_t;

  localparam logic [4:0] DEPTH = 5'(PILE_DEPTH);

  state_t                                state_reg;
  logic [4:0]                            size_reg;
  logic [4:0]                            index_reg;
  logic [PILE_DEPTH-1:0][CARD_SIZE-1:0]  slot;
  logic                                  pop_valid_reg;
  logic [CARD_SIZE-1:0]                  pop_card_reg;
  logic                                  recycle_valid_reg;
  logic [CARD_SIZE-1:0]                  recycle_card_reg;
  logic                                  recycle_last_reg;
  logic                                  recycle_done_reg;
  logic                                  do_push;
  logic                                  do_pop;
  logic                                  do_clear;
  logic [4:0]                            top_idx;

  assign empty      = (size_reg == 5'd0);
  assign full       = (size_reg == DEPTH);
  assign push_ready = (state_reg == IDLE) && !full && !pop_req && !recycle_start;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = (state_reg == POP) && pop_ack;
  assign do_clear   = (state_reg == RECYCLE) && recycle_last_reg;
  assign top_idx    = size_reg - 5'd1;

  assign pile_size     = size_reg;
  assign pop_valid     = pop_valid_reg;
  assign pop_card      = pop_card_reg;
  assign recycle_valid = recycle_valid_reg;
  assign recycle_card  = recycle_card_reg;
  assign recycle_last  = recycle_last_reg;
  assign recycle_done  = recycle_done_reg;

  for (genvar gi = 0; gi < PILE_DEPTH; gi++) begin : gen_slot
    logic [CARD_SIZE-1:0] card_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        card_reg <= '0;
      end else if (do_clear) begin
        card_reg <= '0;
      end else if (do_push && (size_reg == 5'(gi))) begin
        card_reg <= push_card;
      end else if (do_pop && (top_idx == 5'(gi))) begin
        card_reg <= '0;
      end
    end

    assign slot[gi] = card_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      size_reg          <= 5'd0;
      index_reg         <= 5'd0;
      pop_valid_reg     <= 1'b0;
      pop_card_reg      <= '0;
      recycle_valid_reg <= 1'b0;
      recycle_card_reg  <= '0;
      recycle_last_reg  <= 1'b0;
      recycle_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (recycle_start) begin
            // slot[0] goes out on the start edge, so index points at the next card
            index_reg <= 5'd1;
            if (empty) begin
              recycle_done_reg <= 1'b1;
              state_reg        <= DONE;
            end else begin
              recycle_valid_reg <= 1'b1;
              recycle_card_reg  <= slot[0];
              recycle_last_reg  <= (size_reg == 5'd1);
              state_reg         <= RECYCLE;
            end
          end else if (pop_req) begin
            if (!empty) begin
              pop_valid_reg <= 1'b1;
              pop_card_reg  <= slot[top_idx];
              state_reg     <= POP;
            end
          end else if (do_push) begin
            size_reg <= size_reg + 5'd1;
          end
        end
        POP: begin
          if (pop_ack) begin
            pop_valid_reg <= 1'b0;
            pop_card_reg  <= '0;
            size_reg      <= top_idx;
            state_reg     <= IDLE;
          end
        end
        RECYCLE: begin
          if (recycle_last_reg) begin
            recycle_valid_reg <= 1'b0;
            recycle_card_reg  <= '0;
            recycle_last_reg  <= 1'b0;
            recycle_done_reg  <= 1'b1;
            size_reg          <= 5'd0;
            state_reg         <= DONE;
          end else begin
            recycle_card_reg <= slot[index_reg];
            recycle_last_reg <= (index_reg == top_idx);
            index_reg        <= index_reg + 5'd1;
          end
        end
        DONE: begin
          recycle_done_reg <= 1'b0;
          state_reg        <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef STOCK_READER_ERR_EN
  logic err_underflow_reg;
  logic err_overflow_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_underflow_reg <= 1'b0;
      err_overflow_reg  <= 1'b0;
    end else begin
      err_underflow_reg <= (state_reg == IDLE) && !recycle_start && pop_req && empty;
      err_overflow_reg  <= (state_reg == IDLE) && push_valid && full;
    end
  end

  assign err_underflow = err_underflow_reg;
  assign err_overflow  = err_overflow_reg;
`else
  assign err_underflow = 1'b0;
  assign err_overflow  = 1'b0;
`endif

endmodule

// File: doc/stock_pile_reader.md
STOCK_PILE_READER -- requirements
Module: stock_pile_reader

Interface
REQ-001 SHALL have parameter: CARD_SIZE, 6, card encoding width (suit + rank); value 0 means "no card".
REQ-002 SHALL have parameter: PILE_DEPTH, 24, maximum cards held.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: push_valid  input  1  draw logic offers a card for the pile top.
REQ-006 SHALL have port: push_card  input  CARD_SIZE  card offered.
REQ-007 SHALL have port: push_ready  output  1  = (state==IDLE) && !full && !pop_req && !recycle_start.
REQ-008 SHALL have port: pop_req  input  1  consumer (tableau/foundation move) requests the top card.
REQ-009 SHALL have port: pop_valid  output  1  top card presented.
REQ-010 SHALL have port: pop_card  output  CARD_SIZE  presented card; 0 when pop_valid low.
REQ-011 SHALL have port: pop_ack  input  1  consumer took the presented card.
REQ-012 SHALL have port: recycle_start  input  1  stream the whole pile back to the talon.
REQ-013 SHALL have port: recycle_valid / recycle_card / recycle_last  output  1 / CARD_SIZE / 1  recycle stream.
REQ-014 SHALL have port: recycle_done  output  1  one-cycle pulse when recycle completes.
REQ-015 SHALL have port: pile_size  output  5  cards held; empty, full  output  1 each.
REQ-016 SHALL have port: err_underflow, err_overflow  output  1 each  error pulses (see Configuration).

Function
REQ-017 SHALL hold cards in a LIFO array slot[0..PILE_DEPTH-1]; slot[pile_size-1] is the top.
REQ-018 SHALL implement FSM states IDLE, POP, RECYCLE, DONE.
REQ-019 In IDLE, priority SHALL be recycle_start > pop_req > push.
REQ-020 IDLE, push_valid && push_ready at edge: slot[pile_size] <= push_card, pile_size +1; push without ready is dropped, no state change.
REQ-021 IDLE, pop_req with pile_size>0: pop_card <= top, go POP; pop_valid high from the following cycle (1-cycle latency).
REQ-022 IDLE, pop_req with pile_size==0: remain IDLE, pop_valid stays low.
REQ-023 POP: pop_valid and pop_card held stable until pop_ack; deassertion of pop_req does not cancel.
REQ-024 POP, pop_ack at edge: top slot <= 0, pile_size -1, pop_valid low next cycle, go IDLE.
REQ-025 IDLE, recycle_start: index <= 0, go RECYCLE (or DONE directly if pile_size==0).
REQ-026 RECYCLE: one card per cycle, slot[0] first (bottom = oldest drawn), recycle_valid high, no backpressure; recycle_last high with slot[pile_size-1].
REQ-027 After the last card: all slots <= 0, pile_size <= 0, go DONE.
REQ-028 DONE: recycle_done high exactly one cycle, then IDLE; recycle of empty pile yields recycle_done with no recycle_valid.
REQ-029 empty = (pile_size==0); full = (pile_size==PILE_DEPTH); both combinational from pile_size.
REQ-030 pile_size SHALL never exceed PILE_DEPTH nor wrap below 0.
REQ-031 pop_req, push_valid, recycle_start outside IDLE SHALL be ignored.

Reset
REQ-032 rst low SHALL immediately clear all slots, pile_size=0, state=IDLE, all valid/done/error outputs 0, pop_card=0, recycle_card=0.
REQ-033 Reset mid-POP or mid-RECYCLE SHALL abort with no further outputs; empty=1 after release.

Configuration
REQ-034 Macro STOCK_READER_ERR_EN: when defined, err_underflow pulses one cycle for REQ-022 and err_overflow pulses one cycle for push_valid in IDLE while full.
REQ-035 Without STOCK_READER_ERR_EN, err_underflow and err_overflow SHALL be constant 0; all other behaviour identical.

Verification
REQ-036 Push cards 5,12,33 on 3 cycles -> pile_size=3; pop_req -> next cycle pop_valid=1, pop_card=33; pop_ack -> pile_size=2.
REQ-037 Push 24 cards -> full=1, push_ready=0; 25th push_valid -> pile_size stays 24, err_overflow pulse (ERR_EN only).
REQ-038 pile of 1,2,3 + recycle_start -> recycle_card 1,2,3 on consecutive cycles, recycle_last with 3, recycle_done next cycle, pile_size=0.
REQ-039 Same cycle pop_req, push_valid, recycle_start with pile_size=2 -> recycle taken, push_ready=0, push dropped.
REQ-040 pop_req on empty pile -> pop_valid stays 0, err_underflow pulse only with ERR_EN.
REQ-041 rst low during RECYCLE after 2 of 5 cards -> recycle_valid 0 immediately, pile_size=0, no recycle_done.
